md_ctl: RTL and testbench
=========================

# md_ctl

Multiply/divide sequencer for the 5-stage pipeline. It owns the architectural HI/LO registers and decodes the EX-stage instruction for mult, multu, div, divu, mthi, mtlo, mfhi and mflo. It runs multiplies as a fixed-latency pipelined operation and divides as a 32-step restoring divider. It raises `stall` to freeze IF/ID/EX while a HI/LO-class instruction waits for a busy unit.

## Interface
Parameters:
- `MULT_CYCLES`, default 4: busy cycles per multiply. Legal range 1..16.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_ex`  in  32  instruction in the EX stage.
- `ex_valid`  in  1  EX slot holds a real instruction, not a bubble.
- `rs_val`  in  32  forwarded rs operand: dividend, multiplicand, or mthi/mtlo data.
- `rt_val`  in  32  forwarded rt operand: divisor or multiplier.
- `stall`  out  1  combinational; asserted when `ex_valid`, `instr_ex` is a HI/LO-class instruction, and `busy`=1.
- `busy`  out  1  registered; unit is executing a mult/div.
- `hi`  out  32  architectural HI, read by mfhi in the same cycle.
- `lo`  out  32  architectural LO, read by mflo in the same cycle.

## Operation
- Decode: OP=6'b000000 with FUNCT 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu, 0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo. Anything else is ignored.
- Accept condition: `ex_valid` & decoded op & state IDLE. On the same edge:
  - mthi writes `hi`; mtlo writes `lo`.
  - mf* changes no state.
  - mult/div latch their operands and leave IDLE.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE→MUL on mult/multu. Load the 64-bit product and set cnt=MULT_CYCLES-1.
  - MUL: decrement cnt. At cnt=0, write {hi,lo}=product and go to IDLE.
  - IDLE→DIV on div/divu. Signed ops use operand magnitudes and record the quotient sign (sign rs XOR sign rt) and the remainder sign (sign rs). Set step=31.
  - DIV: one restoring shift-subtract per cycle with a 33-bit partial remainder. After step 0, go to FIX.
  - FIX: negate the quotient and/or remainder per the recorded signs, write lo=quotient and hi=remainder, go to IDLE.
- Width rules:
  - multu uses a 32x32 unsigned product; mult uses a signed product. Both are exact 64-bit results: hi=[63:32], lo=[31:0].
  - div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (rt_val=0, signed or unsigned): same latency. Result is hi=rs_val, lo=0xFFFFFFFF.
- `busy` = (state != IDLE).
- No queuing. A second HI/LO-class instruction arriving while busy is held by `stall` until the cycle after the return to IDLE, and is accepted then.

## Timing
- Reset: state=IDLE, `hi`=0, `lo`=0, `busy`=0, `stall`=0. Reset mid-operation aborts it immediately and discards the partial result.
- Multiply accepted at edge E0:
  - `busy`=1 for exactly MULT_CYCLES cycles.
  - hi/lo update at edge E(MULT_CYCLES).
  - A dependent mfhi/mflo that follows immediately stalls MULT_CYCLES cycles.
- Divide accepted at edge E0:
  - DIV edges E1..E32, then FIX writes hi/lo at E33.
  - `busy`=1 for 33 cycles.
- Non-HI/LO instructions never stall and may flow past a busy unit.
- mthi/mtlo while busy stall; they never corrupt an in-flight result.
- `stall` must not depend on `hi`/`lo`. It is a function only of `busy`, `ex_valid` and `instr_ex`.

## Test plan
- Reset, then idle: `hi`=`lo`=0, `busy`=0. mflo with no op in flight: `stall`=0 for all cycles.
- multu 0xFFFFFFFF×0xFFFFFFFF, MULT_CYCLES=4, mfhi directly behind:
  - `stall`=1 for 4 cycles.
  - Result hi=0xFFFFFFFE, lo=0x00000001.
  - mult −3×5 gives hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- divu 100/7: `busy` for 33 cycles, then lo=14, hi=2. div −7/2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Edge divides:
  - div 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0.
  - divu 0x1234/0 gives hi=0x1234, lo=0xFFFFFFFF.
- Ordering and hazards:
  - mthi 0xA5A5A5A5 while idle updates `hi` next edge.
  - mtlo issued during a divide stalls until `busy` falls, then writes. The divide result in hi is preserved.
  - An addu behind mult never stalls.
- Reset mid-operation: assert `rst` at divide cycle 10. Next edge: `busy`=0, hi=lo=0, FSM IDLE. A fresh divu then completes normally.

Source files
------------

// File: rtl/md_ctl.sv
// -----------------------------------------------------------------------------
// md_ctl -- multiply/divide sequencer for the EX stage of the 5-stage pipeline.
//
// Owns the architectural HI/LO registers. It decodes the EX-stage instruction
// for mult, multu, div, divu, mthi, mtlo, mfhi and mflo. Multiplies run with a
// fixed latency of MULT_CYCLES. Divides run on a 32-step restoring divider,
// followed by one sign-fixup cycle. While the unit is busy, any HI/LO-class
// instruction in EX is held back through `stall`.
//
// Parameters
//   MULT_CYCLES  busy cycles per multiply, 1..16
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   instr_ex  instruction currently in EX
//   ex_valid  EX slot holds a real instruction (not a bubble)
//   rs_val    forwarded rs: dividend / multiplicand / mthi-mtlo data
//   rt_val    forwarded rt: divisor / multiplier
//   stall     combinational freeze request for IF/ID/EX
//   busy      registered; a mult/div is in flight
//   hi, lo    architectural HI/LO, readable by mfhi/mflo in the same cycle
// -----------------------------------------------------------------------------
module md_ctl #(
  parameter int MULT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_ex,
  input  logic        ex_valid,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  if (MULT_CYCLES < 1 || MULT_CYCLES > 16) begin : g_bad_param
    $error("md_ctl: MULT_CYCLES must be in 1..16");
  end

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] F_MFHI     = 6'h10;
  localparam logic [5:0] F_MTHI     = 6'h11;
  localparam logic [5:0] F_MFLO     = 6'h12;
  localparam logic [5:0] F_MTLO     = 6'h13;
  localparam logic [5:0] F_MULT     = 6'h18;
  localparam logic [5:0] F_MULTU    = 6'h19;
  localparam logic [5:0] F_DIV      = 6'h1A;
  localparam logic [5:0] F_DIVU     = 6'h1B;

  localparam logic [3:0] CNT_INIT   = 4'(MULT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t      state_q, state_d;
  logic        busy_q;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Datapath working registers
  logic [63:0] prod_q, prod_d;       // multiply result waiting out the latency
  logic [3:0]  cnt_q, cnt_d;         // multiply cycles left
  logic [4:0]  step_q, step_d;       // divide step index, 31 down to 0
  logic [31:0] rem_q, rem_d;         // partial remainder (always < divisor)
  logic [31:0] quo_q, quo_d;         // dividend bits shifting out, quotient bits shifting in
  logic [31:0] dvsr_q, dvsr_d;       // divisor magnitude
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dbz_q, dbz_d;         // divide by zero: lo is forced to all ones

  // ---------------------------------------------------------------------------
  // Decode. Only OP and FUNCT matter; the remaining fields are don't-care.
  // ---------------------------------------------------------------------------
  logic [5:0] funct;
  logic       is_special;
  logic       op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo, op_mf;
  logic       is_hilo;
  logic       accept;
  logic       unused_instr;

  assign funct        = instr_ex[5:0];
  assign is_special   = (instr_ex[31:26] == OP_SPECIAL);
  assign unused_instr = ^instr_ex[25:6];

  assign op_mult  = is_special && (funct == F_MULT);
  assign op_multu = is_special && (funct == F_MULTU);
  assign op_div   = is_special && (funct == F_DIV);
  assign op_divu  = is_special && (funct == F_DIVU);
  assign op_mthi  = is_special && (funct == F_MTHI);
  assign op_mtlo  = is_special && (funct == F_MTLO);
  assign op_mf    = is_special && ((funct == F_MFHI) || (funct == F_MFLO));
  assign is_hilo  = op_mult | op_multu | op_div | op_divu | op_mthi | op_mtlo | op_mf;

  // Stall looks only at busy and the EX instruction, never at hi/lo.
  assign stall  = ex_valid & is_hilo & busy_q;
  assign accept = ex_valid & is_hilo & (state_q == S_IDLE);

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // ---------------------------------------------------------------------------
  // Multiplier. A single 64x64 multiplier whose low 64 bits give the exact
  // signed or unsigned 32x32 product, depending on how the operands are
  // extended.
  // ---------------------------------------------------------------------------
  logic [63:0] mul_a, mul_b, product;

  assign mul_a   = {{32{op_mult & rs_val[31]}}, rs_val};
  assign mul_b   = {{32{op_mult & rt_val[31]}}, rt_val};
  assign product = mul_a * mul_b;

  // ---------------------------------------------------------------------------
  // Divider operand preparation: signed divides run on magnitudes, and the
  // signs are applied again in FIX.
  // ---------------------------------------------------------------------------
  logic        rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag;

  assign rs_neg = op_div & rs_val[31];
  assign rt_neg = op_div & rt_val[31];
  assign rs_mag = rs_neg ? (-rs_val) : rs_val;
  assign rt_mag = rt_neg ? (-rt_val) : rt_val;

  // One restoring step: shift the next dividend bit into the remainder, then
  // try the subtraction. A clear borrow bit means the divisor fit. With a zero
  // divisor every step fits, so the quotient becomes all ones and the
  // remainder becomes the dividend magnitude.
  logic [32:0] partial, diff;
  logic        fits;

  assign partial = {rem_q, quo_q[31]};
  assign diff    = partial - {1'b0, dvsr_q};
  assign fits    = ~diff[32];

  logic [31:0] quo_fix, rem_fix;

  assign quo_fix = neg_quo_q ? (-quo_q) : quo_q;
  assign rem_fix = neg_rem_q ? (-rem_q) : rem_q;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a hold value first, so no path through the case
  // statement leaves a signal unassigned and a latch is never inferred.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op_mthi) begin
            hi_d = rs_val;
          end else if (op_mtlo) begin
            lo_d = rs_val;
          end else if (op_mult || op_multu) begin
            prod_d  = product;
            cnt_d   = CNT_INIT;
            state_d = S_MUL;
          end else if (op_div || op_divu) begin
            rem_d     = '0;
            quo_d     = rs_mag;
            dvsr_d    = rt_mag;
            neg_quo_d = rs_neg ^ rt_neg;
            neg_rem_d = rs_neg;
            dbz_d     = (rt_val == 32'd0);
            step_d    = 5'd31;
            state_d   = S_DIV;
          end
          // mfhi/mflo: read-only, nothing to update
        end
      end

      S_MUL: begin
        if (cnt_q == 4'd0) begin
          hi_d    = prod_q[63:32];
          lo_d    = prod_q[31:0];
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_DIV: begin
        rem_d = fits ? diff[31:0] : partial[31:0];
        quo_d = {quo_q[30:0], fits};
        if (step_q == 5'd0) begin
          state_d = S_FIX;
        end else begin
          step_d = step_q - 5'd1;
        end
      end

      S_FIX: begin
        lo_d    = dbz_q ? 32'hFFFF_FFFF : quo_fix;
        hi_d    = rem_fix;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Architectural state: cleared by reset, which also aborts any operation.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // NOTE: the working registers are left without a reset. Each one is loaded
  // on the accept edge before it is read, so clearing them would only add
  // reset fan-out.
  always_ff @(posedge clk) begin
    prod_q    <= prod_d;
    cnt_q     <= cnt_d;
    step_q    <= step_d;
    rem_q     <= rem_d;
    quo_q     <= quo_d;
    dvsr_q    <= dvsr_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
    dbz_q     <= dbz_d;
  end

endmodule

// File: tb/tb_md_ctl.sv
// -----------------------------------------------------------------------------
// tb_md_ctl -- self-checking bench for md_ctl.
// A table of directed vectors with known answers, hand-written hazard and reset
// sequences, and random operations checked against an arithmetic model of
// HI/LO.
// -----------------------------------------------------------------------------
module tb_md_ctl;

  localparam int MC      = 4;
  localparam int TIMEOUT = 200;

  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MFLO  = 6'h12;
  localparam logic [5:0] MTLO  = 6'h13;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;
  localparam logic [5:0] ADDU  = 6'h21;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_ex;
  logic        ex_valid;
  logic [31:0] rs_val, rt_val;
  logic        stall, busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi, m_lo;   // reference HI/LO

  md_ctl #(.MULT_CYCLES(MC)) dut (
    .clk      (clk),
    .rst      (rst),
    .instr_ex (instr_ex),
    .ex_valid (ex_valid),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .stall    (stall),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] f);
    return {26'd0, f};
  endfunction

  task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    ex_valid = v;
    instr_ex = rtype(f);
    rs_val   = a;
    rt_val   = b;
  endtask

  function automatic int exp_busy(input logic [5:0] f);
    if (f == MULT || f == MULTU) return MC;
    if (f == DIV  || f == DIVU)  return 33;
    return 0;
  endfunction

  // Reference model: applies one accepted instruction to m_hi/m_lo.
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned up;
    logic   [63:0]   p;
    case (f)
      MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      MULTU: begin
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        p  = 64'(up);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      DIV, DIVU: begin
        if (b == 32'd0) begin
          m_hi = a;
          m_lo = 32'hFFFF_FFFF;
        end else begin
          sa = (f == DIV) ? longint'($signed(a)) : longint'({32'd0, a});
          sb = (f == DIV) ? longint'($signed(b)) : longint'({32'd0, b});
          q  = sa / sb;
          r  = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      MTHI: m_hi = a;
      MTLO: m_lo = a;
      default: ;
    endcase
  endfunction

  // Issue one instruction from idle and wait for the unit to go idle again.
  // Returns the number of sampled cycles with busy high.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    @(negedge clk);
    drive(1'b1, f, a, b);
    @(negedge clk);
    drive(1'b0, 6'h00, 32'd0, 32'd0);
    n = 0;
    while (busy && n < TIMEOUT) begin
      n++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    string       name;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int            n;
    logic [5:0]    fsel[6];
    logic [5:0]    f;
    logic [31:0]   a, b;

    vecs[0] = '{"multu_max",   MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{"mult_m3x5",   MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{"divu_100_7",  DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[3] = '{"div_m7_2",    DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{"div_ovf",     DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5] = '{"divu_by0",    DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF};
    vecs[6] = '{"mthi",        MTHI,  32'hA5A5_A5A5, 32'd0,         32'hA5A5_A5A5, 32'hFFFF_FFFF};
    vecs[7] = '{"mtlo",        MTLO,  32'h5A5A_5A5A, 32'd0,         32'hA5A5_A5A5, 32'h5A5A_5A5A};
    vecs[8] = '{"div_by0_neg", DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[9] = '{"div_7_m2",    DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};

    // ---- reset ----
    drive(1'b0, 6'h00, 32'd0, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    m_hi = '0;
    m_lo = '0;

    // mflo with nothing in flight never stalls
    drive(1'b1, MFLO, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("idle_mflo_stall%0d", i), 32'(stall), 32'd0);
      @(negedge clk);
    end
    // non-SPECIAL opcode with a mult funct is ignored
    ex_valid = 1'b1;
    instr_ex = {6'h23, 20'd0, MULT};
    @(negedge clk);
    drive(1'b0, 6'h00, 32'd0, 32'd0);
    check("nonspecial_busy", 32'(busy), 32'd0);

    // ---- directed table ----
    foreach (vecs[i]) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, n);
      check({vecs[i].name, "_busy"}, 32'(n), 32'(exp_busy(vecs[i].f)));
      check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
    end
    m_hi = hi;
    m_lo = lo;

    // ---- mfhi directly behind multu stalls MC cycles ----
    @(negedge clk);
    drive(1'b1, MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    drive(1'b1, MFHI, 32'd0, 32'd0);
    #1;
    n = 0;
    while (stall && n < TIMEOUT) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("mfhi_stall_cycles", 32'(n), 32'(MC));
    check("mfhi_sees_hi", hi, 32'hFFFF_FFFE);
    check("mfhi_sees_lo", lo, 32'h0000_0001);
    @(negedge clk);
    drive(1'b0, 6'h00, 32'd0, 32'd0);
    m_hi = 32'hFFFF_FFFE;
    m_lo = 32'h0000_0001;

    // ---- addu behind mult flows without stalling ----
    drive(1'b1, MULT, 32'hFFFF_FFFD, 32'd5);
    @(negedge clk);
    drive(1'b1, ADDU, 32'd1, 32'd2);
    for (int i = 0; i < MC; i++) begin
      #1;
      check($sformatf("addu_stall%0d", i), 32'(stall), 32'd0);
      check($sformatf("addu_busy%0d", i), 32'(busy), 32'd1);
      @(negedge clk);
    end
    drive(1'b0, 6'h00, 32'd0, 32'd0);
    model(MULT, 32'hFFFF_FFFD, 32'd5);
    check("addu_mult_hi", hi, m_hi);
    check("addu_mult_lo", lo, m_lo);

    // ---- mtlo during a divide waits, then writes; divide hi kept ----
    @(negedge clk);
    drive(1'b1, DIVU, 32'd100, 32'd7);
    @(negedge clk);
    drive(1'b1, MTLO, 32'hDEAD_BEEF, 32'd0);
    #1;
    n = 0;
    while (stall && n < TIMEOUT) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("mtlo_stall_cycles", 32'(n), 32'd33);
    check("mtlo_wait_lo", lo, 32'd14);
    @(negedge clk);
    drive(1'b0, 6'h00, 32'd0, 32'd0);
    #1;
    check("mtlo_written_lo", lo, 32'hDEAD_BEEF);
    check("mtlo_kept_hi", hi, 32'd2);
    m_hi = 32'd2;
    m_lo = 32'hDEAD_BEEF;

    // ---- reset in the middle of a divide ----
    @(negedge clk);
    drive(1'b1, DIVU, 32'h0001_0000, 32'd3);
    @(negedge clk);
    drive(1'b0, 6'h00, 32'd0, 32'd0);
    repeat (9) @(negedge clk);
    check("middiv_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    ex_valid = 1'b1;
    instr_ex = rtype(MFLO);
    #1 check("abort_stall", 32'(stall), 32'd0);
    drive(1'b0, 6'h00, 32'd0, 32'd0);
    m_hi = '0;
    m_lo = '0;
    run_op(DIVU, 32'h0001_0000, 32'd3, n);
    model(DIVU, 32'h0001_0000, 32'd3);
    check("fresh_div_busy", 32'(n), 32'd33);
    check("fresh_div_hi", hi, m_hi);
    check("fresh_div_lo", lo, m_lo);

    // ---- random operations against the model ----
    fsel = '{MULT, MULTU, DIV, DIVU, MTHI, MTLO};
    for (int i = 0; i < 40; i++) begin
      f = fsel[$urandom_range(0, 5)];
      a = rnd_val();
      b = rnd_val();
      run_op(f, a, b, n);
      model(f, a, b);
      check($sformatf("rnd%0d_busy", i), 32'(n), 32'(exp_busy(f)));
      check($sformatf("rnd%0d_hi", i), hi, m_hi);
      check($sformatf("rnd%0d_lo", i), lo, m_lo);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
